text_buffer_ctrl: RTL

//  Owns the character line shown by the VGA text path. Accepts ASCII codes from a

---
 rtl/text_buffer_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/text_buffer_ctrl.sv
// Character-line buffer for the VGA text path: edits a shadow line from a valid/ready
// code stream and copies it to the display array only when a vertical-blank tick arrives.
module text_buffer_ctrl #(
    parameter int         N_CHARS    = 41,
    parameter logic [7:0] BLANK_CHAR = 8'd0,
    parameter logic [7:0] BS_CODE    = 8'd8,
    parameter logic [7:0] CR_CODE    = 8'd13,
    localparam int        CW         = $clog2(N_CHARS + 1)
) (
    input  logic          clk25,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    input  logic          clear_req,
    input  logic          frame_tick,
    output logic [7:0]    char [0:N_CHARS-1],
    output logic [CW-1:0] cursor,
    output logic          busy,
    output logic          overflow
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_COPY  = 2'd2
    } state_t;

    localparam logic [CW-1:0] ZERO     = {CW{1'b0}};
    localparam logic [CW-1:0] ONE      = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] LAST_IDX = CW'(N_CHARS - 1);
    localparam logic [CW-1:0] FULL_POS = CW'(N_CHARS);

    state_t        state_r, state_nxt;
    logic [CW-1:0] idx_r, idx_nxt, cursor_nxt;
    logic          dirty_r, dirty_nxt;
    logic          pend_copy_r, pend_nxt;
    logic          overflow_nxt;
    logic [7:0]    shadow_r [0:N_CHARS-1];
    logic          sh_we_s;
    logic [CW-1:0] sh_addr_s;
    logic [7:0]    sh_data_s;
    logic          copy_we_s;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

    assign in_ready = (state_r == ST_IDLE);
    assign busy     = (state_r == ST_CLEAR) || (state_r == ST_COPY);

    // State register
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Datapath registers: counters, flags, shadow line and display line
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            idx_r       <= ZERO;
            cursor      <= ZERO;
            dirty_r     <= 1'b0;
            pend_copy_r <= 1'b0;
            overflow    <= 1'b0;
            for (int i = 0; i < N_CHARS; i++) begin
                shadow_r[i] <= BLANK_CHAR;
                char[i]     <= BLANK_CHAR;
            end
        end else begin
            idx_r       <= idx_nxt;
            cursor      <= cursor_nxt;
            dirty_r     <= dirty_nxt;
            pend_copy_r <= pend_nxt;
            overflow    <= overflow_nxt;
            if (sh_we_s) begin
                shadow_r[sh_addr_s] <= sh_data_s;
            end
            if (copy_we_s) begin
                char[idx_r] <= shadow_r[idx_r];
            end
        end
    end

    // Next-state and datapath control; a tick seen while busy is remembered in pend_copy
    always_comb begin
        state_nxt    = state_r;
        idx_nxt      = idx_r;
        cursor_nxt   = cursor;
        dirty_nxt    = dirty_r;
        pend_nxt     = pend_copy_r;
        overflow_nxt = 1'b0;
        sh_we_s      = 1'b0;
        sh_addr_s    = idx_r;
        sh_data_s    = BLANK_CHAR;
        copy_we_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (clear_req) begin
                    state_nxt = ST_CLEAR;
                    idx_nxt   = ZERO;
                    pend_nxt  = pend_copy_r | frame_tick;
                end else if ((frame_tick || pend_copy_r) && dirty_r) begin
                    state_nxt = ST_COPY;
                    idx_nxt   = ZERO;
                    pend_nxt  = 1'b0;
                end else begin
                    // a stale request with nothing to copy must not fire later outside blanking
                    pend_nxt = 1'b0;
                    if (in_valid) begin
                        if (is_printable(in_data)) begin
                            if (cursor < FULL_POS) begin
                                sh_we_s    = 1'b1;
                                sh_addr_s  = cursor;
                                sh_data_s  = in_data;
                                cursor_nxt = cursor + ONE;
                                dirty_nxt  = 1'b1;
                            end else begin
                                overflow_nxt = 1'b1;
                            end
                        end else if (in_data == BS_CODE) begin
                            if (cursor != ZERO) begin
                                sh_we_s    = 1'b1;
                                sh_addr_s  = cursor - ONE;
                                cursor_nxt = cursor - ONE;
                                dirty_nxt  = 1'b1;
                            end else begin
                                cursor_nxt = cursor;
                            end
                        end else if (in_data == CR_CODE) begin
                            state_nxt = ST_CLEAR;
                            idx_nxt   = ZERO;
                        end else begin
                            cursor_nxt = cursor;
                        end
                    end else begin
                        cursor_nxt = cursor;
                    end
                end
            end
            ST_CLEAR: begin
                sh_we_s  = 1'b1;
                pend_nxt = pend_copy_r | frame_tick;
                if (idx_r == LAST_IDX) begin
                    state_nxt  = ST_IDLE;
                    idx_nxt    = ZERO;
                    cursor_nxt = ZERO;
                    dirty_nxt  = 1'b1;
                end else begin
                    idx_nxt = idx_r + ONE;
                end
            end
            ST_COPY: begin
                copy_we_s = 1'b1;
                pend_nxt  = pend_copy_r | frame_tick;
                if (idx_r == LAST_IDX) begin
                    state_nxt = ST_IDLE;
                    idx_nxt   = ZERO;
                    dirty_nxt = 1'b0;
                end else begin
                    idx_nxt = idx_r + ONE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                idx_nxt   = ZERO;
            end
        endcase
    end

endmodule
